// File: rtl/memory_responder.sv
// Word-addressed memory on the CPU bus: clears the whole array after reset, then
// serves single-word reads (registered, 1-cycle latency) and writes.
module memory_responder #(
   parameter int                 ADDR_W     = 8,
   parameter int                 DATA_W     = 24,
   parameter int                 DEPTH      = 256,
   parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] MAR,
   input  logic [DATA_W-1:0] MBR_from_cpu,
   output logic [DATA_W-1:0] MBR_to_cpu,
   input  logic              Mem_EN,
   input  logic              Mem_CS,
   output logic              Mem_busy,
   output logic              Mem_rvalid,
   output logic              Mem_err
);

   typedef enum logic {CLEAR, READY} state_t;

   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] cnt;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              in_range;
   logic              mem_we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic              rd_hit;
   logic              rvalid_nxt;
   logic              err_nxt;

   assign in_range = ({1'b0, MAR} < DEPTH_EXT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= CLEAR;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (state == CLEAR) begin
         cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      if (state == CLEAR && cnt == LAST_ADDR) begin
         state_nxt = READY;
      end
   end

   // The sweep owns the single write port while clearing; CPU requests are refused.
   always_comb begin
      mem_we     = 1'b0;
      waddr      = cnt;
      wdata      = INIT_VALUE;
      rd_hit     = 1'b0;
      rvalid_nxt = 1'b0;
      err_nxt    = 1'b0;
      Mem_busy   = (state == CLEAR);
      case (state)
         CLEAR: begin
            mem_we  = 1'b1;
            err_nxt = Mem_EN;
         end
         READY: begin
            if (Mem_EN) begin
               if (!in_range) begin
                  err_nxt    = 1'b1;
                  rvalid_nxt = ~Mem_CS;
               end else if (Mem_CS) begin
                  mem_we = 1'b1;
                  waddr  = MAR;
                  wdata  = MBR_from_cpu;
               end else begin
                  rd_hit     = 1'b1;
                  rvalid_nxt = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         MBR_to_cpu <= '0;
         Mem_rvalid <= 1'b0;
         Mem_err    <= 1'b0;
      end else begin
         Mem_rvalid <= rvalid_nxt;
         Mem_err    <= err_nxt;
         if (rd_hit) begin
            MBR_to_cpu <= mem[MAR];
         end else if (rvalid_nxt) begin
            MBR_to_cpu <= '0;
         end
      end
   end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: a full-depth instance and a DEPTH=200
// instance share one stimulus stream.
module tb_memory_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  mar = '0;
   logic [23:0] wd = '0;
   logic        en = 1'b0;
   logic        cs = 1'b0;

   logic [23:0] rd_a, rd_b;
   logic        busy_a, busy_b, rv_a, rv_b, err_a, err_b;

   int total = 0;
   int bad   = 0;
   int na, nb;
   logic [23:0] last1, last2, expv;

   always #5 clk = ~clk;

   memory_responder #(.ADDR_W(8), .DATA_W(24), .DEPTH(256), .INIT_VALUE(24'h000000)) dut_a (
      .clk(clk), .rst_n(rst_n), .MAR(mar), .MBR_from_cpu(wd), .MBR_to_cpu(rd_a),
      .Mem_EN(en), .Mem_CS(cs), .Mem_busy(busy_a), .Mem_rvalid(rv_a), .Mem_err(err_a)
   );

   memory_responder #(.ADDR_W(8), .DATA_W(24), .DEPTH(200), .INIT_VALUE(24'h000000)) dut_b (
      .clk(clk), .rst_n(rst_n), .MAR(mar), .MBR_from_cpu(wd), .MBR_to_cpu(rd_b),
      .Mem_EN(en), .Mem_CS(cs), .Mem_busy(busy_b), .Mem_rvalid(rv_b), .Mem_err(err_b)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic e, input logic c, input logic [7:0] a, input logic [23:0] d);
      en  = e;
      cs  = c;
      mar = a;
      wd  = d;
   endtask

   // Counts edges until each instance leaves the sweep; probe>0 issues a read on that edge.
   task automatic wait_sweep(input int probe, output int n_a, output int n_b);
      n_a = 0;
      n_b = 0;
      for (int i = 1; i <= 300; i++) begin
         if (i == probe) req(1'b1, 1'b0, 8'h00, 24'h0);
         tick;
         if (i == probe) begin
            chk("clear_req_err", err_a, 1);
            chk("clear_req_rvalid", rv_a, 0);
            chk("clear_req_mbr", rd_a, 0);
            chk("clear_req_err_b", err_b, 1);
            req(1'b0, 1'b0, 8'h00, 24'h0);
         end
         if (!busy_b && n_b == 0) n_b = i;
         if (!busy_a) begin
            n_a = i;
            break;
         end
      end
   endtask

   initial begin
      #1;
      chk("rst_mbr", rd_a, 0);
      chk("rst_rvalid", rv_a, 0);
      chk("rst_err", err_a, 0);
      chk("rst_busy", busy_a, 1);
      chk("rst_busy_b", busy_b, 1);
      tick;
      tick;
      rst_n = 1'b1;

      wait_sweep(10, na, nb);
      chk("sweep_len", na, 256);
      chk("sweep_len_b", nb, 200);

      req(1'b1, 1'b0, 8'h00, 24'h0);
      tick;
      chk("rd00_mbr", rd_a, 24'h000000);
      chk("rd00_rvalid", rv_a, 1);
      chk("rd00_err", err_a, 0);
      req(1'b1, 1'b0, 8'h7F, 24'h0);
      tick;
      chk("rd7f_mbr", rd_a, 24'h000000);
      chk("rd7f_rvalid", rv_a, 1);
      req(1'b1, 1'b0, 8'hFF, 24'h0);
      tick;
      chk("rdff_mbr", rd_a, 24'h000000);
      chk("rdff_rvalid", rv_a, 1);

      req(1'b1, 1'b1, 8'd20, 24'h03A5C1);
      tick;
      chk("wr20_rvalid", rv_a, 0);
      chk("wr20_err", err_a, 0);
      chk("wr20_hold", rd_a, 24'h000000);
      req(1'b1, 1'b0, 8'd20, 24'h0);
      tick;
      chk("rd20_mbr", rd_a, 24'h03A5C1);
      chk("rd20_rvalid", rv_a, 1);
      chk("rd20_err", err_a, 0);
      req(1'b0, 1'b0, 8'd0, 24'h0);
      tick;
      chk("idle_rvalid", rv_a, 0);
      chk("idle_err", err_a, 0);
      chk("idle_hold", rd_a, 24'h03A5C1);

      chk("b_pre_oor_mbr", rd_b, 24'h03A5C1);
      req(1'b1, 1'b0, 8'd210, 24'h0);
      tick;
      chk("oor_rd_mbr", rd_b, 24'h000000);
      chk("oor_rd_rvalid", rv_b, 1);
      chk("oor_rd_err", err_b, 1);
      chk("inr_rd_err", err_a, 0);
      req(1'b1, 1'b1, 8'd210, 24'hFFFFFF);
      tick;
      chk("oor_wr_err", err_b, 1);
      chk("oor_wr_rvalid", rv_b, 0);
      req(1'b1, 1'b0, 8'd210, 24'h0);
      tick;
      chk("oor_rd2_mbr", rd_b, 24'h000000);
      chk("oor_rd2_err", err_b, 1);
      chk("full_wr_mbr", rd_a, 24'hFFFFFF);

      last1 = 24'h0;
      last2 = 24'h0;
      for (int k = 0; k < 20; k++) begin
         if (k % 2 == 0) begin
            expv = 24'h100000 + 24'(k * 24'h010101);
            if ((k / 2) % 2 == 0) begin
               req(1'b1, 1'b1, 8'd1, expv);
               last1 = expv;
            end else begin
               req(1'b1, 1'b1, 8'd2, expv);
               last2 = expv;
            end
            tick;
            chk("alt_wr_rvalid", rv_a, 0);
         end else begin
            if ((k / 2) % 2 == 0) begin
               req(1'b1, 1'b0, 8'd1, 24'h0);
               expv = last1;
            end else begin
               req(1'b1, 1'b0, 8'd2, 24'h0);
               expv = last2;
            end
            tick;
            chk("alt_rd_mbr", rd_a, expv);
            chk("alt_rd_rvalid", rv_a, 1);
         end
      end

      req(1'b1, 1'b1, 8'd5, 24'h123456);
      tick;
      req(1'b1, 1'b0, 8'd5, 24'h0);
      tick;
      chk("rd5_mbr", rd_a, 24'h123456);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_mbr", rd_a, 0);
      chk("async_rst_rvalid", rv_a, 0);
      chk("async_rst_busy", busy_a, 1);
      req(1'b0, 1'b0, 8'd0, 24'h0);
      tick;
      tick;
      rst_n = 1'b1;
      wait_sweep(0, na, nb);
      chk("sweep2_len", na, 256);
      req(1'b1, 1'b1, 8'd6, 24'hABCDEF);
      tick;
      req(1'b1, 1'b0, 8'd6, 24'h0);
      tick;
      chk("rd6_mbr", rd_a, 24'hABCDEF);
      req(1'b1, 1'b0, 8'd5, 24'h0);
      tick;
      chk("rd5_cleared", rd_a, 24'h000000);
      chk("rd5_rvalid", rv_a, 1);
      req(1'b0, 1'b0, 8'd0, 24'h0);
      tick;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
